// File: rtl/simprisc_rtl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : simprisc_rtl_pkg
// Brief   : Shared constants and helpers for the simprisc front-end RTL.
// Revision: 1.0 - initial release
// ============================================================================
package simprisc_rtl_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam int          ILEN         = 32;
    localparam logic [1:0]  OPC_LOW_32   = 2'b11;
    localparam int          PC_STEP      = 4;

    // Low opcode bits 2'b11 mark a full 32-bit encoding; anything else is compressed.
    function automatic logic is_32bit_encoding(input logic [1:0] low_bits);
        return low_bits == OPC_LOW_32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simprisc_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : simprisc_sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
module simprisc_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int               c_aw      = $clog2(DEPTH);
    localparam int               c_cw      = c_aw + 1;
    localparam logic [c_cw-1:0]  c_depth   = c_cw'(DEPTH);
    localparam logic [c_cw-1:0]  c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0]  c_ptr_one = c_aw'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Clear dominates: neither a push nor a pop lands on a clearing edge.
    assign w_push = wr_en && !full  && !clear;
    assign w_pop  = rd_en && !empty && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_buffer
// Brief   : Instruction fetch buffer: legality filter, PC tagging, FWFT queue.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_buffer
    import simprisc_rtl_pkg::*;
#(
    parameter int              DEPTH    = 8,
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    input  logic                     flush,
    input  logic [XLEN-1:0]          flush_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     illegal_err
);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(PC_STEP);

    logic [XLEN-1:0]   r_next_pc;
    logic              r_illegal_err;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_legal;
    logic              w_store;
    logic              w_pop;
    logic [2*XLEN-1:0] w_rd_data;

    assign in_ready    = !w_full && !flush;
    assign out_valid   = !w_empty && !flush;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = out_valid && out_ready;
    assign w_legal     = is_32bit_encoding(in_instr[1:0]);
    assign w_store     = w_push && w_legal;
    assign out_instr   = w_rd_data[XLEN-1:0];
    assign out_pc      = w_rd_data[2*XLEN-1:XLEN];
    assign illegal_err = r_illegal_err;

    // A push is impossible during flush, so dropped words there never raise the error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_pc     <= RESET_PC;
            r_illegal_err <= 1'b0;
        end else begin
            r_illegal_err <= w_push && !w_legal;
            if (flush) begin
                r_next_pc <= {flush_pc[XLEN-1:2], 2'b00};
            end else if (w_store) begin
                r_next_pc <= r_next_pc + c_pc_step;
            end
        end
    end

    simprisc_sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .wr_en   (w_store),
        .wr_data ({r_next_pc, in_instr}),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (count)
    );

endmodule
`default_nettype wire

// File: doc/ifetch_buffer.md
IFETCH_BUFFER -- requirements
Module: ifetch_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning instruction FIFO entries (power of two, 2..64).
REQ-002 The block SHALL have parameter XLEN, default 32, meaning PC and instruction width.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC tagged on the first instruction after reset.
REQ-004 The block SHALL have one clock and an active-low reset; reset is asynchronous. Ports:
  clk  input  1  rising-edge clock.
  rst_n  input  1  asynchronous active-low reset.
  in_valid  input  1  stimulus-side instruction valid.
  in_ready  output  1  buffer can accept.
  in_instr  input  XLEN  raw instruction word.
  out_valid  output  1  instruction available to core fetch.
  out_ready  input  1  core consumes head.
  out_instr  output  XLEN  head instruction.
  out_pc  output  XLEN  PC tagged to head.
  flush  input  1  redirect pulse; discards buffer contents.
  flush_pc  input  XLEN  redirect target.
  count  output  $clog2(DEPTH)+1  current occupancy.
  illegal_err  output  1  one-cycle pulse, dropped non-32-bit encoding.

Function
REQ-005 A push SHALL occur on a rising edge where in_valid && in_ready.
REQ-006 A pop SHALL occur on a rising edge where out_valid && out_ready.
REQ-007 in_ready SHALL equal (count < DEPTH) && !flush, combinationally.
REQ-008 out_valid SHALL equal (count != 0) && !flush; out_instr/out_pc SHALL be the head entry (first-word fall-through).
REQ-009 A word pushed at edge N SHALL be visible on out_* in the cycle after edge N when the buffer was empty.
REQ-010 A pushed word with in_instr[1:0] != 2'b11 SHALL NOT be stored; illegal_err SHALL be 1 for the cycle after that edge; in_ready is unaffected.
REQ-011 Each stored entry SHALL be tagged with next_pc, and next_pc SHALL then increment by 4 modulo 2^XLEN (wraps FFFF_FFFC -> 0000_0000).
REQ-012 Dropped illegal words SHALL NOT advance next_pc.
REQ-013 Simultaneous push and pop SHALL leave count unchanged and preserve order; at count == DEPTH no push is possible even if out_ready is 1.
REQ-014 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-015 On an edge with flush = 1: count, read and write pointers SHALL become 0; next_pc SHALL become {flush_pc[XLEN-1:2], 2'b00}; no push or pop SHALL take effect that edge.
REQ-016 Back-to-back flush cycles SHALL each reload next_pc; the last flush_pc wins.
REQ-017 illegal_err SHALL not be asserted for any word presented during a flush cycle.

Reset
REQ-018 While rst_n = 0: count = 0, pointers = 0, next_pc = RESET_PC, illegal_err = 0, out_valid = 0, in_ready = 1 (flush low).
REQ-019 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); storage array contents need not be cleared.
REQ-020 The first push after rst_n rises SHALL be tagged RESET_PC.

Structure
REQ-021 XLEN default, ILEN = 32, the opcode-low-bits constant 2'b11 and PC_STEP = 4 SHALL live in shared package simprisc_rtl_pkg.
REQ-022 Storage SHALL be one sub-module, simprisc_sync_fifo (width 2*XLEN, depth DEPTH, clear input driven by flush); PC tagging and legality check remain in ifetch_buffer.

Verification
REQ-023 Reset, push 32'h0000_0013 x3, out_ready = 1 -> out_pc 0x0, 0x4, 0x8 in order; count returns to 0.
REQ-024 out_ready = 0, push 9 legal words (DEPTH = 8) -> in_ready = 0 after 8th; count = 8; 9th held by driver; one pop, then 9th accepted with pc 0x20.
REQ-025 Push 32'h0000_4501 (compressed) between two legal words -> illegal_err pulses once; legal words tagged 0x0 and 0x4; count = 2.
REQ-026 Buffer holding 5 entries, flush = 1 with flush_pc = 32'h0000_1003, same-cycle push -> count = 0 next cycle, push discarded, next push tagged 0x0000_1000.
REQ-027 flush_pc = 32'hFFFF_FFF8, push 3 words -> tags FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-028 Random push/pop/flush for 10k cycles against a scoreboard queue model -> zero order, PC or count mismatches; count ≤ DEPTH always; assert rst_n low mid-stream -> out_valid = 0 without waiting for clk.
